bidirectional_piso_serializer: RTL and testbench
================================================

Name: bidirectional_piso_serializer

Overview:
- Parallel-in, serial-out counterpart of the team's bidirectional serial-in shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake, then emits it one bit per enabled cycle, MSB-first (left shift) or LSB-first (right shift).
- Sits on the transmit side, driving the si_left/si_right input of a downstream bidirectional shift register.
- Provides a done pulse and a bubble-aware back-to-back load path.

Parameters:
- WIDTH, 4, word length in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  din/direction valid.
- load_ready  output  1  block can accept a word; high exactly when state is IDLE.
- din  input  WIDTH  parallel word to serialize.
- direction  input  1  1 = shift left (MSB first), 0 = shift right (LSB first); sampled only at load.
- shift_en  input  1  advance one bit this cycle; low stalls.
- so  output  1  serial data out, registered.
- so_valid  output  1  so carries a valid bit this cycle, registered.
- busy  output  1  high when state is SHIFT.
- done  output  1  one-cycle pulse, coincident with the last bit's so_valid.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, shreg=0, dir_q=0, count=0, so=0, so_valid=0, done=0. While reset is asserted, busy=0 and load_ready=1.
- States: IDLE, SHIFT. Use a 1-bit encoding.
- IDLE:
  - load_ready=1.
  - On an edge where load_valid is high: shreg<=din, dir_q<=direction, count<=WIDTH, state<=SHIFT.
  - so_valid<=0 and done<=0 every IDLE edge. so holds its last value.
- SHIFT:
  - load_ready=0. load_valid is ignored and the word is not captured.
  - Edge with shift_en=1:
    - If dir_q=1: so<=shreg[WIDTH-1] and shreg<={shreg[WIDTH-2:0],1'b0}.
    - If dir_q=0: so<=shreg[0] and shreg<={1'b0,shreg[WIDTH-1:1]}.
    - so_valid<=1 and count<=count-1.
  - Edge with shift_en=0: shreg, count and so hold; so_valid<=0; done<=0.
  - Edge with shift_en=1 and count==1 (last bit): the normal shift happens, plus done<=1 and state<=IDLE.
- Latency:
  - First bit is on so at the first enabled edge after the load edge, i.e. at least one cycle after acceptance.
  - With no stalls, the last bit appears WIDTH cycles after the load edge.
- Back-to-back:
  - load_ready rises in the same cycle that done and the last so_valid are high.
  - A load accepted at the next edge produces one bubble cycle (so_valid=0), so the minimum period is WIDTH+1 cycles per word.
- direction changes during SHIFT have no effect; dir_q is latched at load.
- Vacated positions fill with 0. The register is all-zero after the last bit.
- Reset mid-SHIFT aborts the word immediately: no done pulse, and no further so_valid bits.
- count never underflows: SHIFT always exits when count==1.

Decomposition:
- Shared package bidir_shift_pkg holds:
  - default WIDTH;
  - DIR_LEFT=1'b1 and DIR_RIGHT=1'b0;
  - state localparams ST_IDLE=1'b0 and ST_SHIFT=1'b1.
  The package is shared with the receiver-side shift register.
- One sub-module, piso_shift_core: load/shift register with the direction mux and serial tap, with inputs load, shift, dir and din.
- The top level keeps the FSM, the counter and the handshake outputs.

Test Plan:
- Left shift: reset, load din=4'b1011 with direction=1, shift_en held high. Required: so=1,0,1,1 on four consecutive so_valid cycles, and done high with the fourth bit only.
- Right shift: load 4'b1011 with direction=0. Required: so=1,1,0,1. busy is high from the load edge until done, and load_ready=0 throughout.
- Stall: load 4'b0110 with direction=1 and drop shift_en for 2 cycles after the second bit. Required: so_valid=0 for those 2 cycles, so holds 1, and the sequence resumes 1,0 with no lost or duplicated bit.
- Back-to-back: hold load_valid high with 4'b1000 then 4'b0001, both direction=1. Required: so_valid pattern 1111 0 1111, giving bits 1000 then 0001.
- Ignored inputs: during SHIFT, toggle direction and pulse load_valid with din=4'b1111. Required: the original word and direction complete unchanged, and 4'b1111 is never emitted.
- Reset mid-operation: assert rst after the second bit. Required: so=0, so_valid=0, done=0 and busy=0 immediately, load_ready=1, and no done pulse follows.

Source files
------------

// File: rtl/bidir_shift_pkg.sv
// Shared definitions for the bidirectional shift-register family (the receiver-side
// SIPO and this transmit-side PISO).
//   DEFAULT_WIDTH       : default word length in bits
//   DIR_LEFT / DIR_RIGHT: direction encoding (left = MSB first)
//   ST_IDLE / ST_SHIFT  : 1-bit state encoding, wrapped by state_t
package bidir_shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

endpackage

// File: rtl/bidirectional_piso_serializer_if.sv
// Handshake / serial bus of the PISO serializer.
//   load_valid, din, direction : word offer from the producer
//   load_ready                 : serializer can take a word
//   shift_en                   : advance one bit this cycle
//   so, so_valid, done, busy   : serial output and status
// master = word producer / serial consumer, slave = serializer.
interface bidirectional_piso_serializer_if
    import bidir_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] din;
    logic             direction;
    logic             shift_en;
    logic             so;
    logic             so_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid, din, direction, shift_en,
        input  load_ready, so, so_valid, busy, done
    );

    modport slave (
        input  load_valid, din, direction, shift_en,
        output load_ready, so, so_valid, busy, done
    );

endinterface

// File: rtl/piso_shift_core.sv
// Load/shift register of the PISO serializer with direction mux and serial tap.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture din
//   shift    : shift one position towards the tap, filling with 0
//   dir      : latched direction (DIR_LEFT taps the MSB, DIR_RIGHT the LSB)
//   din      : parallel word
//   tap      : bit that leaves the register on the next shift
module piso_shift_core
    import bidir_shift_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    output logic             tap
);

    logic [WIDTH-1:0] shreg_r;

    // Shift register: load has priority, vacated positions fill with zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_r <= {WIDTH{1'b0}};
        end else if (load) begin
            shreg_r <= din;
        end else if (shift) begin
            if (dir == DIR_LEFT) begin
                shreg_r <= {shreg_r[WIDTH-2:0], 1'b0};
            end else begin
                shreg_r <= {1'b0, shreg_r[WIDTH-1:1]};
            end
        end else begin
            shreg_r <= shreg_r;
        end
    end

    assign tap = (dir == DIR_LEFT) ? shreg_r[WIDTH-1] : shreg_r[0];

endmodule

// File: rtl/bidirectional_piso_serializer.sv
// Parallel-in serial-out serializer, MSB-first or LSB-first.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of bidirectional_piso_serializer_if
//              (load_valid/load_ready/din/direction handshake, shift_en,
//               registered so/so_valid, done pulse on the last bit, busy)
// A word is accepted only in IDLE; the FSM returns to IDLE on the edge that
// emits the last bit, so a word offered right then is loaded one edge later,
// leaving a single bubble cycle between back-to-back words.
module bidirectional_piso_serializer
    import bidir_shift_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input logic                             clk,
    input logic                             rst,
    bidirectional_piso_serializer_if.slave  bus
);

    state_t           state_r;
    logic [CNT_W-1:0] count_r;
    logic             dir_r;
    logic             so_r;
    logic             so_valid_r;
    logic             done_r;

    logic             load_s;
    logic             shift_s;
    logic             tap_s;

    assign load_s  = (state_r == IDLE)  && bus.load_valid;
    assign shift_s = (state_r == SHIFT) && bus.shift_en;

    piso_shift_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst   (rst),
        .load  (load_s),
        .shift (shift_s),
        .dir   (dir_r),
        .din   (bus.din),
        .tap   (tap_s)
    );

    // Control FSM: bit counter, latched direction and registered serial outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= {CNT_W{1'b0}};
            dir_r      <= DIR_RIGHT;
            so_r       <= 1'b0;
            so_valid_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    so_valid_r <= 1'b0;
                    done_r     <= 1'b0;
                    if (bus.load_valid) begin
                        dir_r   <= bus.direction;
                        count_r <= CNT_W'(WIDTH);
                        state_r <= SHIFT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bus.shift_en) begin
                        so_r       <= tap_s;
                        so_valid_r <= 1'b1;
                        count_r    <= count_r - CNT_W'(1);
                        // count==1 means this edge emits the last bit.
                        if (count_r == CNT_W'(1)) begin
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            done_r  <= 1'b0;
                            state_r <= SHIFT;
                        end
                    end else begin
                        so_valid_r <= 1'b0;
                        done_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    so_valid_r <= 1'b0;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.so         = so_r;
    assign bus.so_valid   = so_valid_r;
    assign bus.done       = done_r;
    assign bus.load_ready = (state_r == IDLE);
    assign bus.busy       = (state_r == SHIFT);

endmodule

// File: tb/tb_bidirectional_piso_serializer.sv
// Self-checking bench for bidirectional_piso_serializer. The expected bit stream of
// each word is derived from the word and direction alone (MSB-first or LSB-first
// list of bits), and each enabled cycle pops the next expected bit.
module tb_bidirectional_piso_serializer;
    import bidir_shift_pkg::*;

    localparam int W = 4;

    logic clk;
    logic rst;
    int   nerr = 0;
    int   nchk = 0;
    logic last_so;

    bidirectional_piso_serializer_if #(.WIDTH(W)) bus ();

    bidirectional_piso_serializer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a word and wait (bounded) for it to be accepted.
    task automatic do_load(input logic [W-1:0] word, input logic dir);
        int waited;
        waited = 0;
        bus.load_valid = 1'b1;
        bus.din        = word;
        bus.direction  = dir;
        while (bus.load_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        chk("load_wait", 32'(waited < 50), 32'd1);
        tick();
        chk("load_busy", bus.busy, 32'd1);
        chk("load_ready_low", bus.load_ready, 32'd0);
        chk("load_bubble", bus.so_valid, 32'd0);
        chk("load_so_hold", bus.so, 32'(last_so));
        chk("load_done", bus.done, 32'd0);
        bus.load_valid = 1'b0;
    endtask

    // stall_mode: 0 = always enabled, 1 = random stalls, 2 = two stalls after bit 2.
    // hold_valid keeps load_valid high with hold_din during shifting; toggle_dir
    // flips direction every cycle. Both must be ignored by the serializer.
    task automatic do_shift(input logic [W-1:0] word, input logic dir, input int stall_mode,
                            input logic hold_valid, input logic [W-1:0] hold_din,
                            input logic toggle_dir);
        logic exp_q[$];
        int   cyc;
        int   emitted;
        int   stalled;
        logic en;
        logic b;
        cyc = 0;
        emitted = 0;
        stalled = 0;
        for (int k = 0; k < W; k++) begin
            exp_q.push_back(dir ? word[W-1-k] : word[k]);
        end
        if (hold_valid) begin
            bus.load_valid = 1'b1;
            bus.din        = hold_din;
        end
        while (exp_q.size() > 0 && cyc < 200) begin
            case (stall_mode)
                1: en = ($urandom_range(0, 2) != 0);
                2: begin
                    if (emitted == 2 && stalled < 2) begin
                        en = 1'b0;
                        stalled++;
                    end else begin
                        en = 1'b1;
                    end
                end
                default: en = 1'b1;
            endcase
            bus.shift_en = en;
            if (toggle_dir) bus.direction = ~bus.direction;
            tick();
            cyc++;
            if (en) begin
                b = exp_q.pop_front();
                chk("bit_valid", bus.so_valid, 32'd1);
                chk("bit_value", bus.so, 32'(b));
                chk("bit_done", bus.done, 32'(exp_q.size() == 0));
                chk("bit_busy", bus.busy, 32'(exp_q.size() != 0));
                chk("bit_ready", bus.load_ready, 32'(exp_q.size() == 0));
                last_so = b;
                emitted++;
            end else begin
                chk("stall_valid", bus.so_valid, 32'd0);
                chk("stall_so_hold", bus.so, 32'(last_so));
                chk("stall_done", bus.done, 32'd0);
                chk("stall_busy", bus.busy, 32'd1);
            end
        end
        chk("shift_timeout", 32'(cyc < 200), 32'd1);
        bus.load_valid = 1'b0;
    endtask

    // One idle edge with nothing offered: no output activity, stays ready.
    task automatic idle_check();
        tick();
        chk("idle_valid", bus.so_valid, 32'd0);
        chk("idle_done", bus.done, 32'd0);
        chk("idle_busy", bus.busy, 32'd0);
        chk("idle_ready", bus.load_ready, 32'd1);
        chk("idle_so_hold", bus.so, 32'(last_so));
    endtask

    initial begin
        logic [W-1:0] w;
        logic         d;
        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.din        = 4'b0000;
        bus.direction  = 1'b0;
        bus.shift_en   = 1'b0;
        last_so        = 1'b0;
        tick();
        tick();
        chk("rst_so", bus.so, 32'd0);
        chk("rst_valid", bus.so_valid, 32'd0);
        chk("rst_done", bus.done, 32'd0);
        chk("rst_busy", bus.busy, 32'd0);
        chk("rst_ready", bus.load_ready, 32'd1);
        rst = 1'b0;
        tick();

        // Left shift: 1,0,1,1
        do_load(4'b1011, DIR_LEFT);
        do_shift(4'b1011, DIR_LEFT, 0, 1'b0, 4'b0000, 1'b0);
        idle_check();

        // Right shift: 1,1,0,1
        do_load(4'b1011, DIR_RIGHT);
        do_shift(4'b1011, DIR_RIGHT, 0, 1'b0, 4'b0000, 1'b0);
        idle_check();

        // Stall after the second bit
        do_load(4'b0110, DIR_LEFT);
        do_shift(4'b0110, DIR_LEFT, 2, 1'b0, 4'b0000, 1'b0);
        idle_check();

        // Back-to-back with load_valid held high: next load edge is the single bubble
        do_load(4'b1000, DIR_LEFT);
        do_shift(4'b1000, DIR_LEFT, 0, 1'b1, 4'b0001, 1'b0);
        do_load(4'b0001, DIR_LEFT);
        do_shift(4'b0001, DIR_LEFT, 0, 1'b0, 4'b0000, 1'b0);
        idle_check();

        // Ignored inputs during SHIFT: direction toggles, load_valid with 4'b1111
        do_load(4'b1011, DIR_RIGHT);
        do_shift(4'b1011, DIR_RIGHT, 0, 1'b1, 4'b1111, 1'b1);
        idle_check();

        // Reset mid-operation after the second bit
        do_load(4'b1101, DIR_LEFT);
        bus.shift_en = 1'b1;
        tick();
        chk("mid_bit1", bus.so, 32'd1);
        tick();
        chk("mid_bit2", bus.so, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_so", bus.so, 32'd0);
        chk("mid_rst_valid", bus.so_valid, 32'd0);
        chk("mid_rst_done", bus.done, 32'd0);
        chk("mid_rst_busy", bus.busy, 32'd0);
        chk("mid_rst_ready", bus.load_ready, 32'd1);
        last_so = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("post_rst_valid", bus.so_valid, 32'd0);
            chk("post_rst_done", bus.done, 32'd0);
            chk("post_rst_busy", bus.busy, 32'd0);
        end

        // Random words, directions and stalls
        for (int n = 0; n < 20; n++) begin
            w = W'($urandom);
            d = 1'($urandom);
            do_load(w, d);
            do_shift(w, d, 1, 1'b0, 4'b0000, 1'b0);
        end
        idle_check();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
